// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around a single 1-bit full adder.
// Operands arrive on a valid/ready handshake; the result leaves on a second one.

module full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds its payload until then, and the receiver may raise
// ready without waiting for valid (in_ready in IDLE, out_ready at any time).
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic            accept;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic            carry_q, c_msb_q;
   logic [CW-1:0]   cnt_q;
   logic            fa_sum, fa_cout;

   full_add u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         c_msb_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= in_a;
         b_q     <= in_sub ? ~in_b : in_b;
         carry_q <= in_sub;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         res_q   <= {fa_sum, res_q[WIDTH-1:1]};
         a_q     <= {1'b0, a_q[WIDTH-1:1]};
         b_q     <= {1'b0, b_q[WIDTH-1:1]};
         carry_q <= fa_cout;
         // The adder's carry-out at bit WIDTH-2 is the carry into the MSB.
         if (cnt_q == CNT_PENULT) c_msb_q <= fa_cout;
         if (cnt_q != CNT_LAST)   cnt_q   <= cnt_q + CW'(1);
      end
   end

   assign out_sum  = res_q;
   assign out_cout = carry_q;
   assign out_ovf  = c_msb_q ^ carry_q;

endmodule
